// File: rtl/pwm_bridge_array.sv
// rtl/pwm_bridge_array.sv - multi-channel complementary PWM with double-buffered duty and dead-time
module pwm_bridge_array #(
  parameter int N        = 4,
  parameter int PRESCALE = 120,
  parameter int M        = $clog2(PRESCALE),
  parameter int CHANNELS = 2,
  parameter int DEAD     = 2,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ena,
  input  logic                i_wr_en,
  input  logic [CW-1:0]       i_wr_chan,
  input  logic [N-1:0]        i_wr_duty,
  output logic [CHANNELS-1:0] o_pwm_out_A,
  output logic [CHANNELS-1:0] o_pwm_out_B,
  output logic                o_frame_start
);

  localparam int PW = (M < 1) ? 1 : M;
  localparam int DW = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEAD_L  = DW'(DEAD);
  localparam logic [CW:0]   CH_L    = (CW + 1)'(CHANNELS);
  localparam logic [N-1:0]  PH_LAST = '1;

  logic [PW-1:0]       r_presc;
  logic [N-1:0]        r_phase;
  logic                r_ena_d;
  logic                r_frame_start;
  logic [N-1:0]        r_shadow [CHANNELS];
  logic [N-1:0]        r_active [CHANNELS];
  logic [CHANNELS-1:0] r_raw;
  logic [DW-1:0]       r_cnt    [CHANNELS];
  logic [CHANNELS-1:0] r_pwm_a;
  logic [CHANNELS-1:0] r_pwm_b;

  logic                w_run;
  logic                w_step;
  logic                w_wrap;
  logic                w_boundary;
  logic                w_wr_ok;
  logic [CHANNELS-1:0] w_raw_next;

  // The first enabled cycle is treated like a phase update so a restart matches a frame wrap.
  assign w_run      = i_ena && r_ena_d;
  assign w_step     = w_run && (r_presc == PS_LAST);
  assign w_wrap     = w_step && (r_phase == PH_LAST);
  assign w_boundary = (i_ena && !r_ena_d) || w_wrap;
  assign w_wr_ok    = i_wr_en && ({1'b0, i_wr_chan} < CH_L);

  always_comb begin
    w_raw_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_raw_next[c] = (r_phase < r_active[c]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc       <= '0;
      r_phase       <= '0;
      r_ena_d       <= 1'b0;
      r_frame_start <= 1'b0;
      r_raw         <= '0;
      r_pwm_a       <= '0;
      r_pwm_b       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_shadow[c] <= '0;
        r_active[c] <= '0;
        r_cnt[c]    <= '0;
      end
    end else begin
      r_ena_d       <= i_ena;
      r_frame_start <= w_boundary;

      if (!w_run) begin
        r_presc <= '0;
        r_phase <= '0;
      end else if (w_step) begin
        r_presc <= '0;
        r_phase <= r_phase + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      // Active takes the pre-edge shadow, so a write on the boundary edge waits a frame.
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_boundary) r_active[c] <= r_shadow[c];
      end
      if (w_wr_ok) r_shadow[i_wr_chan] <= i_wr_duty;

      for (int c = 0; c < CHANNELS; c++) begin
        if (!w_run) begin
          r_raw[c] <= 1'b0;
          r_cnt[c] <= '0;
        end else begin
          r_raw[c] <= w_raw_next[c];
          if (w_raw_next[c] != r_raw[c]) r_cnt[c] <= '0;
          else if (r_cnt[c] != DEAD_L)   r_cnt[c] <= r_cnt[c] + 1'b1;
        end

        if (!i_ena) begin
          r_pwm_a[c] <= 1'b0;
          r_pwm_b[c] <= 1'b0;
        end else begin
          r_pwm_a[c] <= r_raw[c] && (r_cnt[c] == DEAD_L);
          r_pwm_b[c] <= !r_raw[c] && (r_cnt[c] == DEAD_L);
        end
      end
    end
  end

  assign o_pwm_out_A   = r_pwm_a;
  assign o_pwm_out_B   = r_pwm_b;
  assign o_frame_start = r_frame_start;

endmodule

// File: doc/pwm_bridge_array.md
# pwm_bridge_array

Multi-channel complementary PWM generator for driving H-bridge half-legs in the amplifier output stage. A shared prescaler and phase counter generate the carrier. Each of CHANNELS channels compares a double-buffered N-bit duty against the phase and drives a complementary pair, pwm_out_A and pwm_out_B, with programmable dead-time. The block is the parametrised successor to the single-pair PWM in `main`. It adds multiple channels, frame-synchronous duty updates and shoot-through protection.

## Interface
- N, default 4: duty and phase width; the frame is 2^N steps.
- PRESCALE, default 120: clk cycles per phase step, ≥1.
- M, default $clog2(PRESCALE): prescaler counter width.
- CHANNELS, default 2: number of complementary output pairs, ≥1.
- DEAD, default 2: dead-time in clk cycles, ≥0.
- CW, default max(1,$clog2(CHANNELS)): channel-select width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  run enable; low forces a safe state.
- wr_en  in  1  duty write strobe.
- wr_chan  in  CW  channel index for the write.
- wr_duty  in  N  new duty value.
- pwm_out_A  out  CHANNELS  high-side drive, one bit per channel.
- pwm_out_B  out  CHANNELS  low-side drive, one bit per channel.
- frame_start  out  1  one-cycle pulse at each frame boundary.

## Operation

Reset (rst_n low, asynchronous):
- Prescaler, phase, shadow duties, active duties and dead counters all go to 0.
- pwm_out_A, pwm_out_B and frame_start go to 0.

Prescaler:
- Counts 0..PRESCALE-1 while ena is high.
- Asserts an internal step on the cycle its count equals PRESCALE-1, then wraps to 0.

Phase:
- N-bit counter that increments on each step and wraps from 2^N-1 to 0.

Frame boundary (the phase wrap, and the first cycle after ena rises):
- active_duty[c] <= shadow_duty[c] for all channels.
- frame_start pulses high for one cycle.

Duty writes:
- wr_en with wr_chan < CHANNELS writes shadow_duty[wr_chan] on that edge.
- wr_chan ≥ CHANNELS is ignored.
- Writes are accepted regardless of ena.
- A write on the boundary edge lands in shadow only; active takes the pre-edge shadow. The new value applies one frame later.

Raw compare:
- raw[c] = (phase < active_duty[c]), registered.
- Duty 0 gives raw always 0.
- Duty 2^N-1 gives raw high for 2^N-1 of 2^N steps. 100% duty is not reachable by design.

Dead-time, per channel:
- The saturating counter cnt[c] resets to 0 whenever raw[c] changes. Otherwise it increments, saturating at DEAD.
- pwm_out_A[c] = raw[c] && cnt[c]==DEAD.
- pwm_out_B[c] = !raw[c] && cnt[c]==DEAD.
- Both outputs are registered.
- A and B are never high in the same cycle, for any parameter set.
- DEAD=0 gives plain complementary outputs.
- A raw pulse shorter than DEAD clocks is swallowed: both outputs stay low.

ena low:
- Prescaler and phase are held at 0.
- Dead counters are cleared.
- All A and B outputs go low on the next edge.
- frame_start stays 0.

ena rising:
- Starts a new frame with phase 0 and a frame_start pulse.
- Both outputs of every channel stay low for at least DEAD cycles before either asserts.

## Timing
- Phase advances every PRESCALE clk cycles. Frame length is PRESCALE·2^N cycles.
- Let E be the edge on which phase updates:
  - raw updates at E+1.
  - The falling output drops at E+2.
  - The opposite output rises at E+2+DEAD.
- frame_start is high during the first cycle in which phase==0.
- The duty load is coincident with frame_start. Both outputs reflect the new duty from the same E+2 point.
- Per channel per frame, with raw high H clocks and raw low L=frame−H clocks:
  - A high time is max(0, H−DEAD).
  - B high time is max(0, L−DEAD).
  - These hold in steady state with unchanged duty.
- Reset mid-frame forces all outputs low asynchronously. Operation restarts as on ena rising once rst_n releases.

## Test plan
1. Reset/idle:
   - Stimulus: rst_n=0, then release with ena=0.
   - Required: A=B=0 on all channels and frame_start=0 for 100 cycles.
2. Steady duty (N=4, PRESCALE=4, DEAD=2):
   - Stimulus: write channel 0 duty 8, set ena=1.
   - Required: from the second frame, a 64-cycle frame with A high 30 cycles and B high 30 cycles.
   - Required: exactly one frame_start per 64 cycles.
3. Extremes (same N=4, PRESCALE=4, DEAD=2):
   - Duty 0: A never high; B high continuously once DEAD has elapsed after enable.
   - Duty 15: A high 58 cycles and B high 2 cycles per frame.
4. Double buffering:
   - Stimulus: write duty 4 mid-frame, then write duty 12 on the exact frame_start cycle.
   - Required: the next frame uses duty 4 and the following frame uses 12.
   - Required: an out-of-range wr_chan leaves all duties unchanged.
5. Dead-time swallow:
   - Stimulus: DEAD=5, PRESCALE=4, duty 1 (raw high 4 cycles).
   - Required: A never asserts; B is low for the 4 raw-high cycles plus 5 cycles after.
   - Checker: A&B==0 on every cycle of every test.
6. ena drop mid-frame:
   - Required: all outputs low on the next edge; phase held at 0.
   - On re-enable: a frame_start pulse, and both outputs low for ≥DEAD cycles.
